// File: rtl/alu_pkg.sv
// alu_pkg: shared width default, opcode constants and FSM encoding for alu_issue_ctrl.
package alu_pkg;
    localparam int WIDTH_DEF = 16;
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_ADD_4 = 4'b0100, OP_ADD_6 = 4'b0110;
    localparam logic [3:0] OP_ADD_8 = 4'b1000, OP_ADD_9 = 4'b1001, OP_ADD_A = 4'b1010, OP_ADD_B = 4'b1011;
    localparam logic [3:0] OP_BEQ = 4'b1100, OP_BNE = 4'b1101, OP_BGT = 4'b1110;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/br_resolve.sv
// br_resolve: combinational result flags and branch resolution; branch logic only with ALU_ISSUE_BRANCH_EN.
module br_resolve
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] result_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] off_i,
    output logic             zero_o,
    output logic             pos_o,
    output logic             taken_o,
    output logic [WIDTH-1:0] target_o
);
    assign zero_o = (result_i == '0);
    assign pos_o  = !zero_o;
`ifdef ALU_ISSUE_BRANCH_EN
    assign taken_o  = (op_i == OP_BEQ) ? zero_o : (op_i == OP_BNE) ? !zero_o : (op_i == OP_BGT) ? pos_o : 1'b0;
    assign target_o = (op_i == OP_BEQ || op_i == OP_BNE || op_i == OP_BGT) ? pc_i + off_i : '0;
`else
    logic unused_br;
    assign unused_br = ^{op_i, pc_i, off_i};
    assign taken_o   = 1'b0;
    assign target_o  = '0;
`endif
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: IDLE/EXEC/RESP issue controller around an external combinational ALU.
// Branch resolution is enabled by the ALU_ISSUE_BRANCH_EN macro.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0] req_pc,
    input  logic [WIDTH-1:0] req_off,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_pos,
    output logic             rsp_taken,
    output logic [WIDTH-1:0] rsp_target,
    output logic             busy
);
    state_t           state_q;
    logic             ready_q, valid_q, busy_q, zero_q, pos_q, taken_q;
    logic             br_zero, br_pos, br_taken;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] in0_q, in1_q, result_q, target_q, br_target, pc_v, off_v;
`ifdef ALU_ISSUE_BRANCH_EN
    logic [WIDTH-1:0] pc_q, off_q;
    assign pc_v  = pc_q;
    assign off_v = off_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pc_q  <= '0;
            off_q <= '0;
        end else if (state_q == IDLE && req_valid && ready_q) begin
            pc_q  <= req_pc;
            off_q <= req_off;
        end
`else
    logic unused_req;
    assign unused_req = ^{req_pc, req_off};
    assign pc_v  = '0;
    assign off_v = '0;
`endif
    br_resolve #(.WIDTH(WIDTH)) u_br (
        .op_i(op_q), .result_i(alu_out), .pc_i(pc_v), .off_i(off_v),
        .zero_o(br_zero), .pos_o(br_pos), .taken_o(br_taken), .target_o(br_target)
    );
    // ready is registered so it stays low through reset and rises on the first edge after release
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            op_q     <= '0;
            in0_q    <= '0;
            in1_q    <= '0;
            result_q <= '0;
            target_q <= '0;
            zero_q   <= 1'b0;
            pos_q    <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        op_q    <= req_op;
                        in0_q   <= req_a;
                        in1_q   <= req_b;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_out;
                    zero_q   <= br_zero;
                    pos_q    <= br_pos;
                    taken_q  <= br_taken;
                    target_q <= br_target;
                    valid_q  <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: if (rsp_ready) begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    assign req_ready  = ready_q;
    assign alu_op     = op_q;
    assign alu_in0    = in0_q;
    assign alu_in1    = in1_q;
    assign rsp_valid  = valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_pos    = pos_q;
    assign rsp_taken  = taken_q;
    assign rsp_target = target_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench with a behavioural ALU (0001 and branches subtract, others add).
module tb_alu_issue_ctrl;
    logic        clk = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
    logic [3:0]  req_op = '0, alu_op;
    logic [15:0] req_a = '0, req_b = '0, req_pc = '0, req_off = '0;
    logic [15:0] alu_in0, alu_in1, alu_out, rsp_result, rsp_target;
    logic        rsp_zero, rsp_pos, rsp_taken, busy;
    int          checks = 0, errors = 0;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_off(req_off),
        .alu_op(alu_op), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_pos(rsp_pos), .rsp_taken(rsp_taken),
        .rsp_target(rsp_target), .busy(busy)
    );

    always #5 clk = ~clk;
    always_comb alu_out = (alu_op == 4'b0001 || alu_op[3:2] == 2'b11) ? alu_in0 - alu_in1 : alu_in0 + alu_in1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [3:0] op, input logic [15:0] a, b, pc, off,
                          input logic [15:0] res, input logic z, p, t, input logic [15:0] tgt);
        chk("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_pc = pc; req_off = off;
        tick();
        req_valid = 1'b0; req_a = 16'hdead; req_b = 16'hbeef;
        chk("exec_in0", alu_in0, a);
        chk("exec_in1", alu_in1, b);
        chk("exec_op", alu_op, op);
        chk("exec_busy", busy, 1);
        chk("exec_ready", req_ready, 0);
        chk("exec_valid", rsp_valid, 0);
        tick();
        chk("resp_valid", rsp_valid, 1);
        chk("resp_result", rsp_result, res);
        chk("resp_zero", rsp_zero, z);
        chk("resp_pos", rsp_pos, p);
        chk("resp_taken", rsp_taken, t);
        chk("resp_target", rsp_target, tgt);
        chk("resp_in0_held", alu_in0, a);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("done_valid", rsp_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_in1_held", alu_in1, b);
    endtask

    initial begin
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in0", alu_in0, 0);
        chk("rst_zero", rsp_zero, 0);
        tick();
        chk("rst_ready_held", req_ready, 0);
        reset = 1'b1;
        tick();
        chk("release_ready", req_ready, 1);

        do_req(4'b0000, 16'd5, 16'd7, 16'h0, 16'h0, 16'd12, 1'b0, 1'b1, 1'b0, 16'h0);
        do_req(4'b0001, 16'd9, 16'd9, 16'h0, 16'h0, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0);
        do_req(4'b0001, 16'd0, 16'd1, 16'h0, 16'h0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0);
        do_req(4'b0100, 16'd1, 16'd2, 16'h0010, 16'h0004, 16'd3, 1'b0, 1'b1, 1'b0, 16'h0);
`ifdef ALU_ISSUE_BRANCH_EN
        do_req(4'b1100, 16'd3, 16'd3, 16'h0010, 16'h0004, 16'd0, 1'b1, 1'b0, 1'b1, 16'h0014);
        do_req(4'b1101, 16'd3, 16'd3, 16'h0010, 16'h0004, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0014);
        do_req(4'b1110, 16'd5, 16'd3, 16'hFFFE, 16'h0004, 16'd2, 1'b0, 1'b1, 1'b1, 16'h0002);
`else
        do_req(4'b1100, 16'd3, 16'd3, 16'h0010, 16'h0004, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0);
`endif

        // backpressure: hold the response while a new request waits
        req_valid = 1'b1; req_op = 4'b0000; req_a = 16'd1; req_b = 16'd1;
        tick();
        req_a = 16'd4; req_b = 16'd4;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_result", rsp_result, 16'd2);
            chk("stall_ready", req_ready, 0);
            chk("stall_in0", alu_in0, 16'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("release_valid", rsp_valid, 0);
        chk("release_idle_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("second_accept_in0", alu_in0, 16'd4);
        chk("second_accept_busy", busy, 1);
        tick();
        chk("second_result", rsp_result, 16'd8);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // reset in the middle of EXEC
        req_valid = 1'b1; req_op = 4'b0000; req_a = 16'd2; req_b = 16'd3;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_in0", alu_in0, 0);
        chk("async_result", rsp_result, 0);
        chk("async_ready", req_ready, 0);
        chk("async_pos", rsp_pos, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_valid", rsp_valid, 0);
        tick();
        chk("post_rst_valid2", rsp_valid, 0);
        do_req(4'b0000, 16'd2, 16'd3, 16'h0, 16'h0, 16'd5, 1'b0, 1'b1, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
